// File: rtl/bp_pkg.sv
// bp_pkg: shared kinds, counter encodings and BTB entry metadata for br_predictor.
package bp_pkg;
    typedef enum logic [1:0] {COND = 2'd0, JUMP = 2'd1, CALL = 2'd2, RET = 2'd3} kind_e;
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;
    // Tag and target widths depend on module parameters, so they live in separate arrays.
    typedef struct packed {
        logic       valid;
        kind_e      kind;
        logic [1:0] ctr;
    } btb_meta_t;
    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
        return up ? (c == ST ? ST : c + 2'd1) : (c == SNT ? SNT : c - 2'd1);
    endfunction
endpackage

// File: rtl/bp_ras.sv
// bp_ras: circular return-address stack; a push when full overwrites the oldest entry.
module bp_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_addr,
    output logic [XLEN-1:0] top,
    output logic            empty
);
    localparam int PW = RAS_DEPTH > 1 ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);
    logic [XLEN-1:0] stack [RAS_DEPTH];
    logic [PW-1:0] ptr, top_ptr;
    logic [CW-1:0] cnt;
    assign top_ptr = ptr == '0 ? LAST : ptr - 1'b1;
    assign top     = stack[top_ptr];
    assign empty   = cnt == '0;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push) begin
            ptr <= ptr == LAST ? '0 : ptr + 1'b1;
            cnt <= cnt == FULL ? FULL : cnt + 1'b1;
        end else if (pop && !empty) begin
            ptr <= top_ptr;
            cnt <= cnt - 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) stack[ptr] <= push_addr;
    end
endmodule

// File: rtl/br_predictor.sv
// br_predictor: direct-mapped BTB with 2-bit counters, misprediction detect and statistics.
// Defining BP_RAS_EN adds a return-address stack used for RET predictions.
module br_predictor
    import bp_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ENTRIES   = 16,
    parameter int TAG_W     = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            bp_clear,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_upd_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  kind_e           ex_kind,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            ex_mispredict,
    output logic [31:0]     n_branch,
    output logic [31:0]     n_mispredict
);
    localparam int IDX_W = $clog2(ENTRIES);
    btb_meta_t meta [ENTRIES];
    logic [TAG_W-1:0] tags [ENTRIES];
    logic [XLEN-1:0] tgts [ENTRIES];
    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    btb_meta_t if_e, ex_e, ex_new;
    logic ex_hit, unused_pc_bits;
    logic [XLEN-1:0] btb_tgt;
    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign if_tag = if_pc[IDX_W+2 +: TAG_W];
    assign ex_tag = ex_pc[IDX_W+2 +: TAG_W];
    assign unused_pc_bits = ^{if_pc, ex_pc};
    assign if_e = meta[if_idx];
    assign ex_e = meta[ex_idx];
    assign pred_hit   = if_e.valid && tags[if_idx] == if_tag;
    assign pred_taken = pred_hit && (if_e.kind != COND || if_e.ctr[1]);
    assign pred_target = pred_taken ? btb_tgt : if_pc + XLEN'(4);
    assign ex_mispredict = ex_upd_valid &&
        (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target));
`ifdef BP_RAS_EN
    logic ras_empty;
    logic [XLEN-1:0] ras_top;
    bp_ras #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (ex_upd_valid && ex_kind == CALL),
        .pop       (ex_upd_valid && ex_kind == RET),
        .push_addr (ex_pc + XLEN'(4)),
        .top       (ras_top),
        .empty     (ras_empty)
    );
    assign btb_tgt = (if_e.kind == RET && !ras_empty) ? ras_top : tgts[if_idx];
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    assign btb_tgt = tgts[if_idx];
`endif
    assign ex_hit = ex_e.valid && tags[ex_idx] == ex_tag;
    assign ex_new = ex_hit
        ? btb_meta_t'{valid: 1'b1, kind: ex_e.kind,
                      ctr: ex_e.kind == COND ? ctr_step(ex_e.ctr, ex_taken) : ST}
        : btb_meta_t'{valid: 1'b1, kind: ex_kind, ctr: ex_kind == COND ? WT : ST};
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < ENTRIES; i++) meta[i] <= btb_meta_t'{valid: 1'b0, kind: COND, ctr: WNT};
            n_branch     <= '0;
            n_mispredict <= '0;
        end else begin
            if (ex_upd_valid) n_branch <= n_branch + 32'd1;
            if (ex_mispredict) n_mispredict <= n_mispredict + 32'd1;
            if (bp_clear) begin
                for (int i = 0; i < ENTRIES; i++) meta[i].valid <= 1'b0;
            end else if (ex_upd_valid && (ex_hit || ex_taken)) begin
                meta[ex_idx] <= ex_new;
            end
        end
    end
    // Only taken outcomes carry a target; a taken hit rewrites the same tag.
    always_ff @(posedge clk) begin
        if (!bp_clear && ex_upd_valid && ex_taken) begin
            tags[ex_idx] <= ex_tag;
            tgts[ex_idx] <= ex_target;
        end
    end
endmodule

// File: doc/br_predictor.md
# br_predictor

Parametrised dynamic branch predictor for the 5-stage pipeline. It replaces the fixed static prediction path between IF and EX. IF gets a same-cycle taken/target prediction from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. EX writes resolved outcomes back, and the block reports mispredictions and keeps prediction statistics.

## Interface
Parameters:
- XLEN, 32, address/data width
- ENTRIES, 16, BTB entries; power of two, ≥2
- TAG_W, 8, stored tag bits; TAG_W ≤ XLEN−log2(ENTRIES)−2
- RAS_DEPTH, 4, return-address-stack depth; used only with BP_RAS_EN

Ports:
- Clock and reset (already decided): one clock `clk`; reset `n_rst` is asynchronous and active-low.
- bp_clear  in  1  synchronous invalidate of all BTB entries
- if_pc  in  XLEN  fetch PC to predict
- pred_hit  out  1  BTB tag match for if_pc
- pred_taken  out  1  predict redirect
- pred_target  out  XLEN  predicted next PC (if_pc+4 when not taken)
- ex_upd_valid  in  1  resolved control-transfer instruction in EX this cycle
- ex_pc  in  XLEN  PC of that instruction
- ex_kind  in  2  bp_pkg kind: COND, JUMP, CALL, RET
- ex_taken  in  1  actual outcome (JUMP/CALL/RET always 1)
- ex_target  in  XLEN  actual target
- ex_pred_taken  in  1  prediction carried down the pipeline
- ex_pred_target  in  XLEN  predicted target carried down the pipeline
- ex_mispredict  out  1  flush request
- n_branch  out  32  resolved-update count
- n_mispredict  out  32  misprediction count

## Operation
- Index = pc[IDX_W+1:2], where IDX_W = log2(ENTRIES). Tag = the TAG_W bits directly above the index.
- Entry fields: valid, tag, kind, 2-bit ctr, target.
- Lookup is combinational from if_pc.
  - pred_hit = valid && tag match.
  - pred_taken = pred_hit && (kind≠COND || ctr[1]).
  - pred_target = entry target when pred_taken, else if_pc+4. Addition wraps modulo 2^XLEN.
- ex_mispredict = ex_upd_valid && (ex_taken≠ex_pred_taken || (ex_taken && ex_target≠ex_pred_target)). This is combinational in EX.
- Update happens at the edge when ex_upd_valid=1:
  - Hit on a COND entry: ctr saturates up on taken and down on not-taken (00..11). Target is rewritten when taken.
  - Miss and taken: allocate, overwriting the occupant. ctr=10 for COND, 11 otherwise; store tag, kind, target.
  - Miss and not taken: no allocation.
  - Non-COND hit: target rewritten, ctr held at 11.
- Counters, wrapping at 2^32:
  - n_branch increments on every ex_upd_valid.
  - n_mispredict increments on every ex_mispredict.
- bp_clear clears all valid bits. It has priority over an update in the same cycle. The counters and RAS are unaffected.

## Timing
- Prediction has zero latency: same cycle as if_pc.
- An update is visible to lookups from the cycle after the edge.
- Same-index lookup and update in one cycle: the lookup sees the old entry.
- Reset values:
  - All valid=0, all ctr=01.
  - n_branch=0, n_mispredict=0.
  - RAS pointer and count = 0.
  - Resulting outputs: pred_hit=0, pred_taken=0, pred_target=if_pc+4.
  - ex_mispredict is purely combinational from the EX inputs and follows them through reset.
- Reset asserted mid-operation discards all learned state immediately, without waiting for clk.

## Configuration
- BP_RAS_EN defined:
  - A RAS_DEPTH-entry return address stack is instantiated.
  - Push ex_pc+4 on an update with kind CALL. Pop on an update with kind RET.
  - Push when full overwrites the oldest entry (circular pointer).
  - Pop when empty is ignored.
  - A lookup hitting a RET entry predicts the RAS top when the stack is non-empty, else the stored BTB target.
  - CALL and RET in the same cycle are impossible (single EX); no arbitration is required.
- BP_RAS_EN undefined: no RAS logic. RET entries behave as JUMP and predict the stored target.

## Structure
- bp_pkg holds:
  - kind enum: COND=0, JUMP=1, CALL=2, RET=3.
  - 2-bit counter constants: SNT=00, WNT=01, WT=10, ST=11.
  - The BTB entry struct.
- Sub-module bp_ras: circular stack with push/pop/top/empty, parametrised by XLEN and RAS_DEPTH. It is instantiated only under BP_RAS_EN.

## Test plan
- Reset, then if_pc=0x100 → pred_hit=0, pred_taken=0, pred_target=0x104, counters 0.
- COND taken at pc 0x40 to 0x80 (ex_pred_taken=0) → ex_mispredict=1, n_mispredict=1. The next cycle if_pc=0x40 gives pred_taken=1, pred_target=0x80.
- Same branch, outcome sequence T,T,N,N,N from WT:
  - ctr steps 11,11,10,01,00.
  - Predictions at if_pc=0x40 after each update: 1,1,1,0,0.
- Aliasing, ENTRIES=16: a branch at 0x40 and one at 0x80 share an index (tags differ, index 0). After the 0x80 update, lookup at 0x40 → pred_hit=0.
- bp_clear together with an update at 0x40 → next lookup at 0x40 misses. n_branch still increments.
- BP_RAS_EN, RAS_DEPTH=4:
  - Five CALLs from 0x10,0x20,0x30,0x40,0x50 (oldest overwritten).
  - RET entry lookups predict, in order: 0x54, 0x44, 0x34, 0x24, then the stored BTB target once empty.
